// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, control bundle and the bubble (all-zero) control word.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_e;

    localparam int MAX_WAIT_DEF = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_hold;
        logic mem_error;
    } hz_ctrl_t;

    // Bubble/NOP control word: nothing advances, nothing is written.
    localparam hz_ctrl_t CTRL_NOP  = '0;
    localparam hz_ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_HOLD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_ERR  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_wait_timer.sv
// Saturating dmem wait counter with a last-allowed-cycle flag.
// Counts held cycles of a stalled data-memory access.
module hazard_wait_timer
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          run,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          timeout
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= CW'(1);
        end else if (run && (r_cnt != CW'(MAX_WAIT))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign count   = r_cnt;
    assign timeout = (r_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/bubble/flush/freeze sequencer for the 5-stage RV32 pipeline.
// Optional HAZARD_PERF_EN adds saturating stall_cnt and flush_cnt outputs.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IFID_rs1,
    input  logic [4:0]  IFID_rs2,
    input  logic        IFID_uses_rs2,
    input  logic [4:0]  IDEX_rd,
    input  logic        IDEX_mem_read,
    input  logic        EX_branch_taken,
    input  logic        EXMEM_mem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        IFID_write,
    output logic        IDEX_bubble,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        pipe_hold,
    output logic        mem_error,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic [1:0]  ctrl_state
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    hz_state_e     r_state;
    hz_state_e     w_next;
    hz_ctrl_t      w_ctrl;
    logic          w_start;
    logic          w_run;
    logic          w_clear;
    logic [CW-1:0] w_count;
    logic          w_timeout;
    logic          w_load_use;
    logic          w_expire;

    hazard_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (w_start),
        .run     (w_run),
        .clear   (w_clear),
        .count   (w_count),
        .timeout (w_timeout)
    );

    assign w_load_use = IDEX_mem_read && (IDEX_rd != 5'd0) &&
                        ((IDEX_rd == IFID_rs1) ||
                         (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));

    assign w_expire = w_timeout && (w_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_ctrl  = CTRL_NOP;
        w_next  = r_state;
        w_start = 1'b0;
        w_run   = 1'b0;
        w_clear = 1'b0;
        if (!reset) begin
            case (r_state)
                RUN: begin
                    w_ctrl = CTRL_RUN;
                    if (EXMEM_mem_req && !dmem_ready) begin
                        w_ctrl  = CTRL_HOLD;
                        w_next  = MEM_WAIT;
                        w_start = 1'b1;
                    end else if (EX_branch_taken) begin
                        w_ctrl.ifid_flush = 1'b1;
                        w_ctrl.idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_ctrl = CTRL_NOP;
                        w_ctrl.idex_bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        w_ctrl = CTRL_HOLD;
                        w_run  = 1'b1;
                        if (w_expire) begin
                            w_next = ERR;
                        end
                    end else begin
                        // Release: a branch or load-use frozen behind the access acts now.
                        w_ctrl  = CTRL_RUN;
                        w_next  = RUN;
                        w_clear = 1'b1;
                        if (EX_branch_taken) begin
                            w_ctrl.ifid_flush = 1'b1;
                            w_ctrl.idex_flush = 1'b1;
                        end else if (w_load_use) begin
                            w_ctrl = CTRL_NOP;
                            w_ctrl.idex_bubble = 1'b1;
                        end
                    end
                end
                ERR: begin
                    w_ctrl = CTRL_ERR;
                end
                default: begin
                    w_ctrl = CTRL_ERR;
                    w_next = ERR;
                end
            endcase
        end
    end

    assign pc_write    = w_ctrl.pc_write;
    assign IFID_write  = w_ctrl.ifid_write;
    assign IDEX_bubble = w_ctrl.idex_bubble;
    assign IFID_flush  = w_ctrl.ifid_flush;
    assign IDEX_flush  = w_ctrl.idex_flush;
    assign pipe_hold   = w_ctrl.pipe_hold;
    assign mem_error   = w_ctrl.mem_error;
    assign ctrl_state  = reset ? 2'b00 : r_state;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_live;

    assign w_live = (r_state != ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_live) begin
            if ((w_ctrl.idex_bubble || w_ctrl.pipe_hold) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_ctrl.ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
